// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package pri_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int ONEHOT_W   = 64;

    // Out-of-range indices return all-zero so callers never set a bit >= n.
    function automatic logic [ONEHOT_W-1:0] onehot(input int idx, input int n);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < ONEHOT_W) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pri_sel.sv
// Combinational selector: rotate by ptr, find highest set bit, un-rotate.
// Returns 0 when vec is empty; result is always < N.
module pri_sel
    import pri_enc_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx
);

    localparam logic [W:0] N_W = (W+1)'(N);

    logic [W-1:0]   base;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   hit;
    logic           found;
    logic [W:0]     sum;

    always_comb begin
        base  = (MODE == MODE_RR) ? ptr : '0;
        // rot[k] = vec[(k + base) mod N]; the top of rot is searched first
        dbl   = {vec, vec} >> base;
        rot   = dbl[N-1:0];
        hit   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rot[k]) begin
                hit   = W'(k);
                found = 1'b1;
            end
        end
        sum = {1'b0, hit} + {1'b0, base};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = found ? sum[W-1:0] : '0;
    end

endmodule

// File: rtl/pri_enc_hs.sv
// Sticky-request priority encoder with a registered valid/ready grant output.
// One-cycle request-to-grant latency; a stalled grant holds while new requests accumulate.
module pri_enc_hs
    import pri_enc_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         CLR,
    input  logic [N-1:0] I,
    input  logic         Ready,
    output logic [W-1:0] Y,
    output logic         Valid,
    output logic [N-1:0] Pend,
    output logic         Idle
);

    logic [N-1:0] p_q, p_d, p_nxt, clrbit;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d, ptr_nxt;
    logic [W-1:0] sel_idx;
    logic         acc;

    always_comb begin
        acc     = valid_q & Ready;
        clrbit  = acc ? N'(onehot(int'(y_q), N)) : '0;
        // A request arriving on the accepted bit re-arms it rather than being lost
        p_nxt   = (p_q & ~clrbit) | I;
        ptr_nxt = acc ? y_q : ptr_q;
    end

    pri_sel #(
        .N    (N),
        .MODE (MODE)
    ) u_sel (
        .vec (p_nxt),
        .ptr (ptr_nxt),
        .idx (sel_idx)
    );

    always_comb begin
        p_d     = p_nxt;
        ptr_d   = ptr_nxt;
        y_d     = y_q;
        valid_d = valid_q;
        if (!valid_q || acc) begin
            valid_d = |p_nxt;
            y_d     = sel_idx;
        end
        if (CLR) begin
            p_d     = '0;
            ptr_d   = '0;
            y_d     = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            p_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            p_q     <= p_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Y     = y_q;
    assign Valid = valid_q;
    assign Pend  = p_q;
    assign Idle  = ~valid_q & ~(|p_q);

endmodule

// File: tb/tb_pri_enc_hs.sv
// Three encoder instances (N=8 fixed, N=8 round-robin, N=5 round-robin) driven in lockstep
// and checked against a queue-fed reference model plus directed expectations.
module tb_pri_enc_hs;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       CLR;
    logic       Ready;
    logic [7:0] req;

    logic [2:0] y0, y1, y2;
    logic       v0, v1, v2;
    logic [7:0] p0, p1;
    logic [4:0] p2;
    logic       idle0, idle1, idle2;

    always #5 CLK = ~CLK;

    pri_enc_hs #(.N(8), .MODE(0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .CLR(CLR), .I(req), .Ready(Ready),
        .Y(y0), .Valid(v0), .Pend(p0), .Idle(idle0));
    pri_enc_hs #(.N(8), .MODE(1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .CLR(CLR), .I(req), .Ready(Ready),
        .Y(y1), .Valid(v1), .Pend(p1), .Idle(idle1));
    pri_enc_hs #(.N(5), .MODE(1)) dut2 (
        .CLK(CLK), .RSTn(RSTn), .CLR(CLR), .I(req[4:0]), .Ready(Ready),
        .Y(y2), .Valid(v2), .Pend(p2), .Idle(idle2));

    typedef struct packed {
        logic [2:0][31:0] s;
    } snap_t;

    snap_t sbq[$];
    int total = 0;
    int bad   = 0;

    int         nn[3] = '{8, 8, 5};
    int         md[3] = '{0, 1, 1};
    logic [7:0] m_pend[3];
    logic       m_valid[3];
    int         m_y[3];
    int         m_last[3];

    function automatic logic [31:0] mk(logic v, logic idl, logic [2:0] y, logic [7:0] p);
        return {19'd0, v, idl, y, p};
    endfunction

    function automatic logic [31:0] pack(int k);
        case (k)
            0:       return mk(v0, idle0, y0, p0);
            1:       return mk(v1, idle1, y1, p1);
            default: return mk(v2, idle2, y2, {3'b000, p2});
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit is_pend(int k, int c);
        return ((m_pend[k] >> c) & 8'd1) != 8'd0;
    endfunction

    // Next grant: fixed scans downward from N-1; round-robin scans last-1, last-2, ... mod N.
    function automatic int pick(int k);
        int c;
        if (md[k] == 0) begin
            for (int i = nn[k] - 1; i >= 0; i--) begin
                if (is_pend(k, i)) return i;
            end
        end else begin
            for (int s = 1; s <= nn[k]; s++) begin
                c = (m_last[k] - s + nn[k]) % nn[k];
                if (is_pend(k, c)) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k]  = 8'h00;
            m_valid[k] = 1'b0;
            m_y[k]     = 0;
            m_last[k]  = 0;
        end
    endtask

    task automatic model_step(int k, logic [7:0] i, logic clr, logic rdy);
        bit acc;
        int c;
        logic [7:0] mask;
        if (clr) begin
            m_pend[k] = 8'h00; m_valid[k] = 1'b0; m_y[k] = 0; m_last[k] = 0;
            return;
        end
        mask = 8'((1 << nn[k]) - 1);
        acc  = m_valid[k] && rdy;
        if (acc) begin
            m_pend[k] = m_pend[k] & ~(8'd1 << m_y[k]);
            m_last[k] = m_y[k];
        end
        m_pend[k] = m_pend[k] | (i & mask);
        if (!m_valid[k] || acc) begin
            c          = pick(k);
            m_valid[k] = (c >= 0);
            m_y[k]     = (c >= 0) ? c : 0;
        end
    endtask

    // Drive one cycle of inputs and queue what every instance should show after the edge.
    task automatic cyc(logic [7:0] i, logic clr, logic rdy);
        snap_t e;
        @(negedge CLK);
        req = i; CLR = clr; Ready = rdy;
        for (int k = 0; k < 3; k++) begin
            model_step(k, i, clr, rdy);
            e.s[k] = mk(m_valid[k], !m_valid[k] && m_pend[k] == 8'h00, 3'(m_y[k]), m_pend[k]);
        end
        sbq.push_back(e);
    endtask

    task automatic post();
        @(posedge CLK);
        #3;
    endtask

    initial begin
        snap_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("sb_dut%0d", k), pack(k), e.s[k]);
                end
            end
        end
    end

    initial begin
        RSTn = 1'b0; CLR = 1'b0; Ready = 1'b0; req = 8'h00;
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_dut%0d", k), pack(k), mk(1'b0, 1'b1, 3'd0, 8'h00));
        @(negedge CLK);
        RSTn = 1'b1;

        // Two requests in one pulse drain highest first
        cyc(8'hA0, 1'b0, 1'b1); post(); chk("fix_a0_first", pack(0), mk(1'b1, 1'b0, 3'd7, 8'hA0));
        cyc(8'h00, 1'b0, 1'b1); post(); chk("fix_a0_second", pack(0), mk(1'b1, 1'b0, 3'd5, 8'h20));
        cyc(8'h00, 1'b0, 1'b1); post(); chk("fix_a0_idle", pack(0), mk(1'b0, 1'b1, 3'd0, 8'h00));

        // Stalled grant holds while a higher request accumulates
        cyc(8'h04, 1'b0, 1'b0); post(); chk("stall_grant", pack(0), mk(1'b1, 1'b0, 3'd2, 8'h04));
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h80, 1'b0, 1'b0); post(); chk("stall_hold", pack(0), mk(1'b1, 1'b0, 3'd2, 8'h84));
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1); post(); chk("stall_release", pack(0), mk(1'b1, 1'b0, 3'd7, 8'h80));
        cyc(8'h00, 1'b0, 1'b1); post(); chk("stall_drain", pack(0), mk(1'b0, 1'b1, 3'd0, 8'h00));

        // Held 0x81: fixed repeats 7, round-robin alternates
        cyc(8'h00, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            cyc(8'h81, 1'b0, 1'b1); post();
            chk("held_fixed", pack(0), mk(1'b1, 1'b0, 3'd7, 8'h81));
            chk("held_rr", pack(1), mk(1'b1, 1'b0, (j % 2 == 0) ? 3'd7 : 3'd0, 8'h81));
        end

        // Full sweep in round-robin for N=8 and N=5, then pointer wrap
        cyc(8'h00, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) begin
            cyc((j == 0) ? 8'hFF : 8'h00, 1'b0, 1'b1); post();
            chk("rr8_sweep", pack(1), mk(1'b1, 1'b0, 3'(7 - j), 8'((9'd1 << (8 - j)) - 9'd1)));
            if (j < 5) chk("rr5_sweep", pack(2), mk(1'b1, 1'b0, 3'(4 - j), 8'((9'd1 << (5 - j)) - 9'd1)));
            else       chk("rr5_done", pack(2), mk(1'b0, 1'b1, 3'd0, 8'h00));
        end
        cyc(8'h00, 1'b0, 1'b1); post(); chk("rr8_idle", pack(1), mk(1'b0, 1'b1, 3'd0, 8'h00));
        cyc(8'h01, 1'b0, 1'b1); post(); chk("rr8_wrap", pack(1), mk(1'b1, 1'b0, 3'd0, 8'h01));

        // Clear beats a same-cycle request; re-request on the accepted bit stays pending
        cyc(8'h10, 1'b1, 1'b0); post();
        chk("clr_wins_fix", pack(0), mk(1'b0, 1'b1, 3'd0, 8'h00));
        chk("clr_wins_rr", pack(1), mk(1'b0, 1'b1, 3'd0, 8'h00));
        cyc(8'h10, 1'b0, 1'b0); post(); chk("rearm_setup", pack(0), mk(1'b1, 1'b0, 3'd4, 8'h10));
        cyc(8'h10, 1'b0, 1'b1); post(); chk("rearm_kept", pack(0), mk(1'b1, 1'b0, 3'd4, 8'h10));

        // Asynchronous reset mid-handshake drops the grant at once
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h3C, 1'b0, 1'b0); post(); chk("pre_reset", pack(0), mk(1'b1, 1'b0, 3'd5, 8'h3C));
        RSTn = 1'b0; req = 8'h00;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("async_reset_dut%0d", k), pack(k), mk(1'b0, 1'b1, 3'd0, 8'h00));
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;

        // Random traffic against the model
        for (int j = 0; j < 400; j++) begin
            cyc(8'($urandom & $urandom & $urandom), ($urandom_range(31) == 0), ($urandom_range(3) != 0));
        end

        repeat (3) @(posedge CLK);
        #4;
        chk("queue_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
